// File: rtl/gpu_thread_decoder.sv
// gpu_thread_decoder
//   Per-lane operand decode stage. Latches one 142-bit warp instruction word,
//   resolves op1/op2 from the register bank, memory or the immediate field,
//   reconciles op2 to op1's size, then holds the resolved bundle for the
//   execute stage.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   instr_valid/instr_ready/instr instruction intake (ready only in IDLE)
//   bank_rd_en/idx/data{1,2}      register-bank read, data one cycle after strobe
//   mem_req/out/ack/in{1,2}       memory read, req held until ack
//   dec_valid/dec_ready           decoded bundle handshake
//   dec_opcode, dec_op1, dec_op2, dec_size, dec_dst_is_mem, dec_dst, dec_error
//
// Build option
//   GPU_DECODE_SIGN_EXT_EN : op2 desc bit [2] selects sign extension of a
//   narrower op2; without it a narrower op2 is always zero-extended.

module gpu_thread_decoder (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [141:0] instr,
   output logic         bank_rd_en1,
   output logic         bank_rd_en2,
   output logic [5:0]   bank_rd_idx1,
   output logic [5:0]   bank_rd_idx2,
   input  logic [63:0]  bank_rd_data1,
   input  logic [63:0]  bank_rd_data2,
   output logic         mem_req1,
   output logic         mem_req2,
   output logic [63:0]  mem_out1,
   output logic [63:0]  mem_out2,
   input  logic         mem_ack1,
   input  logic         mem_ack2,
   input  logic [63:0]  mem_in1,
   input  logic [63:0]  mem_in2,
   output logic         dec_valid,
   input  logic         dec_ready,
   output logic [4:0]   dec_opcode,
   output logic [63:0]  dec_op1,
   output logic [63:0]  dec_op2,
   output logic [1:0]   dec_size,
   output logic         dec_dst_is_mem,
   output logic [63:0]  dec_dst,
   output logic         dec_error
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   localparam logic [1:0] OP2_REG = 2'b00;
   localparam logic [1:0] OP2_MEM = 2'b01;
   localparam logic [1:0] OP2_IMM = 2'b10;
   localparam logic [1:0] OP2_BAD = 2'b11;

   state_t        state_q, state_d;
   logic [141:0]  ir_q;
   logic [63:0]   op1_q, op2_q;
   logic          done1, done2;

   logic [3:0]    d1;
   logic [4:0]    d2;
   logic          op1_mem, op2_bad, sx;
   logic [1:0]    op2_type;
   logic          op1_res, op2_res;
   logic [63:0]   op1_cur, op2_cur;
   logic [63:0]   m1, m2, op2_ext, rec_op1, rec_op2;
   logic          unused_bits;

   function automatic logic [63:0] size_mask(input logic [1:0] s);
      case (s)
         2'b00:   return 64'h0000_0000_0000_00FF;
         2'b01:   return 64'h0000_0000_0000_FFFF;
         2'b10:   return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   assign d1       = ir_q[136:133];
   assign d2       = ir_q[132:128];
   assign op1_mem  = d1[0];
   assign op2_type = d2[1:0];
   assign op2_bad  = (op2_type == OP2_BAD);

`ifdef GPU_DECODE_SIGN_EXT_EN
   assign sx = d2[2];
`else
   assign sx = 1'b0;
`endif

   // op1 desc bit [1] is reserved; bit [2] of op2 desc only matters with sign extension
   assign unused_bits = ^{ir_q[134], ir_q[130]};

   assign instr_ready    = (state_q == IDLE);
   assign dec_valid      = (state_q == OUT);
   assign bank_rd_en1    = (state_q == ISSUE) && !op1_mem && !op2_bad;
   assign bank_rd_en2    = (state_q == ISSUE) && (op2_type == OP2_REG);
   assign bank_rd_idx1   = ir_q[69:64];
   assign bank_rd_idx2   = ir_q[5:0];
   assign mem_out1       = ir_q[127:64];
   assign mem_out2       = ir_q[63:0];
   assign dec_opcode     = ir_q[141:137];
   assign dec_size       = d1[3:2];
   assign dec_dst_is_mem = op1_mem;
   assign dec_dst        = ir_q[127:64];

   // An operand is resolved if already captured, or if its data is arriving
   // this cycle (bank data in WAIT, or an ack on a pending request). Using the
   // live value lets the last operand and the size fixup share one edge.
   assign op1_res = done1 || (!op1_mem && state_q == WAIT) || (mem_req1 && mem_ack1);
   assign op2_res = done2 || (op2_type == OP2_REG && state_q == WAIT) || (mem_req2 && mem_ack2);
   assign op1_cur = done1 ? op1_q : (op1_mem ? mem_in1 : bank_rd_data1);
   assign op2_cur = done2 ? op2_q : ((op2_type == OP2_MEM) ? mem_in2 : bank_rd_data2);

   always_comb begin
      m1      = size_mask(d1[3:2]);
      m2      = size_mask(d2[4:3]);
      op2_ext = op2_cur & m2;
      // msb of op2's own width set -> fill everything above it
      if (sx && |(op2_ext & ~(m2 >> 1)))
         op2_ext = op2_ext | ~m2;
      rec_op1 = op1_cur & m1;
      rec_op2 = op2_ext & m1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (instr_valid) state_d = ISSUE;
         ISSUE:   state_d = op2_bad ? OUT : WAIT;
         WAIT:    if (op1_res && op2_res) state_d = OUT;
         OUT:     if (dec_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_q      <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         done1     <= 1'b0;
         done2     <= 1'b0;
         mem_req1  <= 1'b0;
         mem_req2  <= 1'b0;
         dec_op1   <= '0;
         dec_op2   <= '0;
         dec_error <= 1'b0;
      end else begin
         if (state_q == IDLE && instr_valid) begin
            ir_q     <= instr;
            op2_q    <= instr[63:0];      // immediate is resolved at intake
            done1    <= 1'b0;
            done2    <= (instr[129:128] == OP2_IMM);
            // requests go up with the accept edge so an ack can land in ISSUE
            mem_req1 <= instr[133] && (instr[129:128] != OP2_BAD);
            mem_req2 <= (instr[129:128] == OP2_MEM);
         end
         if (mem_req1 && mem_ack1) begin
            op1_q    <= mem_in1;
            done1    <= 1'b1;
            mem_req1 <= 1'b0;
         end
         if (mem_req2 && mem_ack2) begin
            op2_q    <= mem_in2;
            done2    <= 1'b1;
            mem_req2 <= 1'b0;
         end
         if (state_q == WAIT && !done1 && !op1_mem) begin
            op1_q <= bank_rd_data1;
            done1 <= 1'b1;
         end
         if (state_q == WAIT && !done2 && op2_type == OP2_REG) begin
            op2_q <= bank_rd_data2;
            done2 <= 1'b1;
         end
         if (state_q == ISSUE && op2_bad) begin
            dec_op1   <= '0;
            dec_op2   <= '0;
            dec_error <= 1'b1;
         end
         if (state_q == WAIT && op1_res && op2_res) begin
            dec_op1   <= rec_op1;
            dec_op2   <= rec_op2;
            dec_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gpu_thread_decoder.sv
// Self-checking bench for gpu_thread_decoder: register bank and memory
// responders, expected bundles queued at issue and compared at dec_valid.
module tb_gpu_thread_decoder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [141:0] instr = '0;
   logic         bank_rd_en1, bank_rd_en2;
   logic [5:0]   bank_rd_idx1, bank_rd_idx2;
   logic [63:0]  bank_rd_data1 = '0, bank_rd_data2 = '0;
   logic         mem_req1, mem_req2;
   logic [63:0]  mem_out1, mem_out2;
   logic         mem_ack1 = 1'b0, mem_ack2 = 1'b0;
   logic [63:0]  mem_in1 = '0, mem_in2 = '0;
   logic         dec_valid;
   logic         dec_ready = 1'b0;
   logic [4:0]   dec_opcode;
   logic [63:0]  dec_op1, dec_op2;
   logic [1:0]   dec_size;
   logic         dec_dst_is_mem;
   logic [63:0]  dec_dst;
   logic         dec_error;

   gpu_thread_decoder dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .bank_rd_en1(bank_rd_en1), .bank_rd_en2(bank_rd_en2),
      .bank_rd_idx1(bank_rd_idx1), .bank_rd_idx2(bank_rd_idx2),
      .bank_rd_data1(bank_rd_data1), .bank_rd_data2(bank_rd_data2),
      .mem_req1(mem_req1), .mem_req2(mem_req2),
      .mem_out1(mem_out1), .mem_out2(mem_out2),
      .mem_ack1(mem_ack1), .mem_ack2(mem_ack2),
      .mem_in1(mem_in1), .mem_in2(mem_in2),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_opcode(dec_opcode), .dec_op1(dec_op1), .dec_op2(dec_op2),
      .dec_size(dec_size), .dec_dst_is_mem(dec_dst_is_mem),
      .dec_dst(dec_dst), .dec_error(dec_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  opc;
      logic [63:0] op1, op2, dst;
      logic [1:0]  size;
      logic        is_mem, err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, t0 = 0;
   int          dly1 = 0, dly2 = 0, cnt1 = 0, cnt2 = 0;
   logic        inj1 = 1'b0;
   logic        pe1 = 1'b0, pe2 = 1'b0;
   logic [5:0]  pi1 = '0, pi2 = '0;
   int          nstb = 0;
   logic [63:0] last_op2 = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] reg_val(input logic [5:0] i);
      return 64'hF0E1_D2C3_B4A5_9687 ^ {8{2'b00, i}};
   endfunction

   function automatic logic [63:0] mem_val(input logic [63:0] a);
      return {a[31:0] ^ 32'h8BAD_F00D, ~a[63:32]};
   endfunction

   // bitwise reference: keep w1 bits; below w2 copy op2, above it fill with sign or 0
   function automatic logic [63:0] fit(input logic [63:0] a, input logic [1:0] s1,
                                       input logic [1:0] s2, input bit sx);
      int w1 = 8 << s1;
      int w2 = 8 << s2;
      logic [63:0] r = '0;
      for (int i = 0; i < 64; i++)
         if (i < w1) r[i] = (i < w2) ? a[i] : (sx & a[w2-1]);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // activity monitor for the illegal-operand case
   always @(negedge clk)
      if (bank_rd_en1 || bank_rd_en2 || mem_req1 || mem_req2) nstb++;

   // register bank: data appears after the edge following the strobe and is
   // held for that whole cycle; otherwise junk so a mistimed capture shows
   always @(negedge clk) begin
      pe1 = bank_rd_en1; pi1 = bank_rd_idx1;
      pe2 = bank_rd_en2; pi2 = bank_rd_idx2;
   end
   always @(posedge clk) begin
      #1;
      bank_rd_data1 = pe1 ? reg_val(pi1) : 64'hDEAD_BEEF_DEAD_BEEF;
      bank_rd_data2 = pe2 ? reg_val(pi2) : 64'hDEAD_BEEF_DEAD_BEEF;
   end

   // memory: ack after dlyN cycles of a held request (0 = first cycle)
   always @(negedge clk) begin
      if (mem_req1 && !mem_ack1) begin
         if (cnt1 >= dly1) begin mem_ack1 = 1'b1; mem_in1 = mem_val(mem_out1); end
         else begin cnt1++; mem_in1 = 64'hBAD0_BAD0_BAD0_BAD0; end
      end else begin
         mem_ack1 = inj1; cnt1 = 0; mem_in1 = 64'hBAD1_BAD1_BAD1_BAD1;
      end
   end
   always @(negedge clk) begin
      if (mem_req2 && !mem_ack2) begin
         if (cnt2 >= dly2) begin mem_ack2 = 1'b1; mem_in2 = mem_val(mem_out2); end
         else begin cnt2++; mem_in2 = 64'hBAD2_BAD2_BAD2_BAD2; end
      end else begin
         mem_ack2 = 1'b0; cnt2 = 0; mem_in2 = 64'hBAD3_BAD3_BAD3_BAD3;
      end
   end

   task automatic send(input logic [4:0] opc, input logic [3:0] d1, input logic [4:0] d2,
                       input logic [63:0] f1, input logic [63:0] f2,
                       input int dl1, input int dl2, input bit push);
      exp_t e;
      logic [63:0] a1, a2;
      bit sx;
      int dmax = 0;
      a1 = d1[0] ? mem_val(f1) : reg_val(f1[5:0]);
      case (d2[1:0])
         2'b00:   a2 = reg_val(f2[5:0]);
         2'b01:   a2 = mem_val(f2);
         default: a2 = f2;
      endcase
`ifdef GPU_DECODE_SIGN_EXT_EN
      sx = d2[2];
`else
      sx = 1'b0;
`endif
      if (d1[0] && dl1 > dmax) dmax = dl1;
      if (d2[1:0] == 2'b01 && dl2 > dmax) dmax = dl2;
      e.opc = opc; e.dst = f1; e.size = d1[3:2]; e.is_mem = d1[0];
      if (d2[1:0] == 2'b11) begin
         e.op1 = '0; e.op2 = '0; e.err = 1'b1; e.lat = 2;
      end else begin
         e.op1 = fit(a1, d1[3:2], d1[3:2], 1'b0);
         e.op2 = fit(a2, d1[3:2], d2[4:3], sx);
         e.err = 1'b0;
         e.lat = (dmax + 2 > 3) ? dmax + 2 : 3;
      end
      if (push) sb.push_back(e);
      dly1 = dl1; dly2 = dl2;
      instr = {opc, d1, d2, f1, f2};
      instr_valid = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      instr_valid = 1'b0;
   endtask

   // lat = index of the edge (relative to accept) at which dec_valid is first sampled high
   task automatic collect(input int hold);
      exp_t e;
      int n = 0;
      logic [63:0] s1, s2;
      do begin @(negedge clk); n++; end while (!dec_valid && n < 100);
      if (!dec_valid) begin
         chk("dec_valid_timeout", 64'(dec_valid), 64'd1);
         if (sb.size() > 0) e = sb.pop_front();
         return;
      end
      if (sb.size() == 0) begin
         chk("unexpected_output", 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      chk("latency", 64'(cyc - t0 + 1), 64'(e.lat));
      chk("dec_op1", dec_op1, e.op1);
      chk("dec_op2", dec_op2, e.op2);
      chk("dec_error", 64'(dec_error), 64'(e.err));
      chk("dec_opcode", 64'(dec_opcode), 64'(e.opc));
      chk("dec_size", 64'(dec_size), 64'(e.size));
      chk("dec_dst", dec_dst, e.dst);
      chk("dec_dst_is_mem", 64'(dec_dst_is_mem), 64'(e.is_mem));
      chk("busy_ready", 64'(instr_ready), 64'd0);
      last_op2 = dec_op2;
      s1 = dec_op1; s2 = dec_op2;
      for (int i = 0; i < hold; i++) begin
         // offered words while busy must be ignored
         instr = {14'($urandom), 64'({$urandom, $urandom}), 64'({$urandom, $urandom})};
         instr_valid = 1'b1;
         @(negedge clk);
         chk("hold_valid", 64'(dec_valid), 64'd1);
         chk("hold_op1", dec_op1, s1);
         chk("hold_op2", dec_op2, s2);
         chk("hold_opcode", 64'(dec_opcode), 64'(e.opc));
         chk("hold_ready", 64'(instr_ready), 64'd0);
      end
      instr_valid = 1'b0;
      dec_ready = 1'b1;
      @(posedge clk); #1;
      dec_ready = 1'b0;
      chk("post_valid", 64'(dec_valid), 64'd0);
      chk("post_ready", 64'(instr_ready), 64'd1);
   endtask

   initial begin
      int s;
      logic [3:0] rd1;
      logic [4:0] rd2;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(instr_ready), 64'd1);
      chk("rst_valid", 64'(dec_valid), 64'd0);
      chk("rst_req", 64'({mem_req1, mem_req2, bank_rd_en1, bank_rd_en2}), 64'd0);
      chk("rst_op1", dec_op1, 64'd0);
      chk("rst_err", 64'(dec_error), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // reg op1 idx 5 (32b), imm op2 (32b)
      send(5'd3, 4'b1000, 5'b10010, 64'd5, 64'hFFFF_FFFF_1234_5678, 0, 0, 1'b1);
      @(negedge clk);
      chk("t1_bank_en1", 64'(bank_rd_en1), 64'd1);
      chk("t1_bank_idx1", 64'(bank_rd_idx1), 64'd5);
      chk("t1_no_mem", 64'({mem_req1, mem_req2}), 64'd0);
      collect(0);
      chk("t1_imm", last_op2, 64'h0000_0000_1234_5678);

      // both mem, 64b; ack2 after 1 cycle, ack1 after 4
      send(5'd7, 4'b1101, 5'b11001, 64'h100, 64'h200, 4, 1, 1'b1);
      @(negedge clk);
      chk("t2_out1", mem_out1, 64'h100);
      chk("t2_out2", mem_out2, 64'h200);
      chk("t2_req", 64'({mem_req1, mem_req2}), 64'b11);
      @(negedge clk);
      @(negedge clk);
      chk("t2_req2_dropped", 64'({mem_req1, mem_req2}), 64'b10);
      collect(0);

      // 8-bit imm 0x80 with sign flag into 32-bit op1
      send(5'd9, 4'b1000, 5'b00110, 64'd12, 64'h80, 0, 0, 1'b1);
      collect(0);
`ifdef GPU_DECODE_SIGN_EXT_EN
      chk("t3_movsx", last_op2, 64'h0000_0000_FFFF_FF80);
`else
      chk("t3_movzx", last_op2, 64'h0000_0000_0000_0080);
`endif

      // illegal op2: no activity, error at T0+2
      s = nstb;
      send(5'd1, 4'b1100, 5'b11011, 64'd9, 64'd4, 0, 0, 1'b1);
      collect(0);
      chk("t4_no_activity", 64'(nstb - s), 64'd0);

      // reset while mem_req1 pending, then a stale ack
      send(5'd2, 4'b1101, 5'b11000, 64'h300, 64'd7, 50, 0, 1'b0);
      @(negedge clk); @(negedge clk);
      chk("t5_req_pending", 64'(mem_req1), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t5_req_dropped", 64'(mem_req1), 64'd0);
      chk("t5_ready", 64'(instr_ready), 64'd1);
      rst_n = 1'b1;
      inj1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 1) inj1 = 1'b0;
         chk("t5_no_output", 64'({dec_valid, mem_req1}), 64'd0);
         chk("t5_idle", 64'(instr_ready), 64'd1);
      end
      @(posedge clk); #1;

      // hold dec_ready low for 5 cycles (16b reg op1, 8b mem op2)
      send(5'd17, 4'b0100, 5'b00001, 64'd33, 64'h44, 0, 2, 1'b1);
      collect(5);

      // random legal mixes, back-to-back
      for (int k = 0; k < 12; k++) begin
         rd1 = {2'($urandom), 1'($urandom), 1'($urandom)};
         rd2 = {2'($urandom), 1'($urandom), 2'($urandom_range(0, 2))};
         send(5'($urandom), rd1, rd2, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
         collect(k % 3);
      end

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
